// File: rtl/spi_ram_burst_slave.sv
// SPI slave with an on-chip single-port RAM and streaming burst access.
// One SPI bit is handled per clk edge while SS_n is low. A 2-bit command
// selects address load, streaming write, or streaming read. An early SS_n
// rise during an address field, a data word, or the command produces a
// one-cycle abort pulse.
module spi_ram_burst_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic busy,
    output logic abort
);

    // The shared receive shift register is as wide as the larger field.
    localparam int RW    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW    = $clog2(RW + 1);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [CW-1:0]         A_LAST   = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0]         D_LAST   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_STEP = (AUTO_INC != 0) ? ADDR_WIDTH'(1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WADDR,
        WDATA,
        RADDR,
        RTURN,
        RDATA
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  cmd_msb_q, cmd_msb_d;
    logic                  addr_done_q, addr_done_d;
    logic [RW-1:0]         rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] pre_q, pre_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic                  miso_q, miso_d;
    logic                  abort_q, abort_d;

    logic [RW-1:0]         rx_shift;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  frame_abort;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rx_shift  = {rx_sr_q[RW-2:0], MOSI};
    assign mem_rdata = mem[rptr_q];

    // State register; reset returns the FSM to IDLE from anywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SS_n high always ends the frame, otherwise walk the command.
    always_comb begin
        state_d = state_q;
        if (SS_n) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = CMD;
                CMD: begin
                    unique case ({cmd_msb_q, MOSI})
                        2'b00:   state_d = WADDR;
                        2'b01:   state_d = WDATA;
                        2'b10:   state_d = RADDR;
                        default: state_d = RTURN;
                    endcase
                end
                RTURN:   state_d = RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Output logic: busy follows the state, MISO and abort come straight from flops.
    always_comb begin
        busy  = (state_q != IDLE);
        MISO  = miso_q;
        abort = abort_q;
    end

    // A frame that ends while a field or word is half received is an abort.
    always_comb begin
        frame_abort = 1'b0;
        unique case (state_q)
            CMD:          frame_abort = 1'b1;
            WADDR, RADDR: frame_abort = !addr_done_q;
            WDATA:        frame_abort = (bit_cnt_q != '0);
            default:      frame_abort = 1'b0;
        endcase
    end

    // Datapath next-values: field shifting, RAM write strobe, read prefetch and pointer updates.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        cmd_msb_d   = cmd_msb_q;
        addr_done_d = addr_done_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        pre_d       = pre_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        miso_d      = 1'b0;
        abort_d     = 1'b0;
        mem_we      = 1'b0;

        if (SS_n) begin
            bit_cnt_d   = '0;
            addr_done_d = 1'b0;
            rx_sr_d     = '0;
            abort_d     = frame_abort;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cmd_msb_d = MOSI;
                    bit_cnt_d = '0;
                end
                CMD: begin
                    bit_cnt_d   = '0;
                    addr_done_d = 1'b0;
                    rx_sr_d     = '0;
                end
                WADDR, RADDR: begin
                    if (!addr_done_q) begin
                        rx_sr_d   = rx_shift;
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                        if (bit_cnt_q == A_LAST) begin
                            addr_done_d = 1'b1;
                            if (state_q == WADDR) begin
                                wptr_d = rx_shift[ADDR_WIDTH-1:0];
                            end else begin
                                rptr_d = rx_shift[ADDR_WIDTH-1:0];
                            end
                        end
                    end
                end
                WDATA: begin
                    rx_sr_d = rx_shift;
                    if (bit_cnt_q == D_LAST) begin
                        bit_cnt_d = '0;
                        mem_we    = 1'b1;
                        wptr_d    = wptr_q + PTR_STEP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
                RTURN: begin
                    tx_sr_d   = mem_rdata;
                    rptr_d    = rptr_q + PTR_STEP;
                    bit_cnt_d = '0;
                end
                RDATA: begin
                    miso_d  = tx_sr_q[DATA_WIDTH-1];
                    tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == '0) begin
                        pre_d = mem_rdata;
                    end
                    if (bit_cnt_q == D_LAST) begin
                        tx_sr_d   = (bit_cnt_q == '0) ? mem_rdata : pre_q;
                        rptr_d    = rptr_q + PTR_STEP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    bit_cnt_d = bit_cnt_q;
                end
            endcase
        end
    end

    // Datapath registers; reset clears pointers and shift registers but not the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            cmd_msb_q   <= 1'b0;
            addr_done_q <= 1'b0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            pre_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            miso_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            cmd_msb_q   <= cmd_msb_d;
            addr_done_q <= addr_done_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            pre_q       <= pre_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            miso_q      <= miso_d;
            abort_q     <= abort_d;
        end
    end

    // RAM write port, updated on the edge that samples a word's last bit.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= rx_shift[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Bench for spi_ram_burst_slave: instance A bursts with auto-increment,
// instance B keeps the pointer fixed. Read frames push expected words into
// per-instance queues; a monitor assembles MISO bits and compares each word.
module tb_spi_ram_burst_slave;

    logic clk;
    logic rst;
    logic mosi;
    logic ss_n_a, ss_n_b;
    logic miso_a, miso_b;
    logic busy_a, busy_b;
    logic abort_a, abort_b;

    logic samp_a, samp_b;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int n_checks;
    int n_pass;
    int abort_cnt_a;
    int abort_cnt_b;

    spi_ram_burst_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1)) dut_a (
        .clk(clk), .rst(rst), .MOSI(mosi), .SS_n(ss_n_a),
        .MISO(miso_a), .busy(busy_a), .abort(abort_a)
    );

    spi_ram_burst_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(0)) dut_b (
        .clk(clk), .rst(rst), .MOSI(mosi), .SS_n(ss_n_b),
        .MISO(miso_b), .busy(busy_b), .abort(abort_b)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runaway guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive n bits MSB first on the selected instance, one per cycle.
    task automatic applyStimulus(input bit sel, input logic [31:0] bits, input int n, input bit samp);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            if (sel) begin
                ss_n_b = 1'b0;
                samp_b = samp;
            end else begin
                ss_n_a = 1'b0;
                samp_a = samp;
            end
            mosi = bits[i];
        end
    endtask

    task automatic end_frame(input bit sel);
        @(negedge clk);
        if (sel) ss_n_b = 1'b1;
        else     ss_n_a = 1'b1;
        mosi   = 1'b0;
        samp_a = 1'b0;
        samp_b = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic wr_addr(input bit sel, input logic [7:0] addr);
        applyStimulus(sel, {22'd0, 2'b00, addr}, 10, 1'b0);
        end_frame(sel);
    endtask

    task automatic rd_addr(input bit sel, input logic [7:0] addr);
        applyStimulus(sel, {22'd0, 2'b10, addr}, 10, 1'b0);
        end_frame(sel);
    endtask

    task automatic wr_data(input bit sel, input logic [31:0] words, input int n);
        applyStimulus(sel, 32'b01, 2, 1'b0);
        applyStimulus(sel, words, 8 * n, 1'b0);
        end_frame(sel);
    endtask

    // Read n words; expected words are queued before the frame starts.
    task automatic rd_data(input bit sel, input logic [31:0] words, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) exp_b.push_back(words[8*(n-1-i) +: 8]);
            else     exp_a.push_back(words[8*(n-1-i) +: 8]);
        end
        applyStimulus(sel, 32'b110, 3, 1'b0);
        applyStimulus(sel, 32'hFFFF_FFFF, 8 * n, 1'b1);
        end_frame(sel);
    endtask

    // Monitor: counts abort cycles and assembles sampled MISO bits into words.
    initial begin
        logic [7:0] acc_a, acc_b;
        int nb_a, nb_b;
        logic [7:0] want;
        acc_a = '0; acc_b = '0; nb_a = 0; nb_b = 0;
        forever begin
            @(posedge clk);
            #2;
            if (abort_a === 1'b1) abort_cnt_a++;
            if (abort_b === 1'b1) abort_cnt_b++;
            if (samp_a) begin
                acc_a = {acc_a[6:0], miso_a};
                nb_a++;
                if (nb_a == 8) begin
                    nb_a = 0;
                    if (exp_a.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL rd_word_a: got 0x%0h, expected no word", acc_a);
                    end else begin
                        want = exp_a.pop_front();
                        checkOutput("rd_word_a", {24'd0, acc_a}, {24'd0, want});
                    end
                end
            end
            if (samp_b) begin
                acc_b = {acc_b[6:0], miso_b};
                nb_b++;
                if (nb_b == 8) begin
                    nb_b = 0;
                    if (exp_b.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL rd_word_b: got 0x%0h, expected no word", acc_b);
                    end else begin
                        want = exp_b.pop_front();
                        checkOutput("rd_word_b", {24'd0, acc_b}, {24'd0, want});
                    end
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        n_checks = 0; n_pass = 0; abort_cnt_a = 0; abort_cnt_b = 0;
        rst = 1'b1; mosi = 1'b0; ss_n_a = 1'b1; ss_n_b = 1'b1;
        samp_a = 1'b0; samp_b = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_miso", {31'd0, miso_a}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("reset_abort", {31'd0, abort_a}, 32'd0);
        checkOutput("reset_busy_b", {31'd0, busy_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single write/read");
        wr_addr(1'b0, 8'h12);
        wr_data(1'b0, 32'hA5, 1);
        rd_addr(1'b0, 8'h12);
        rd_data(1'b0, 32'hA5, 1);
        settle();
        checkOutput("single_no_abort", abort_cnt_a, 0);

        $display("[TB] burst write with wrap");
        wr_addr(1'b0, 8'hFE);
        wr_data(1'b0, 32'h112233, 3);
        wr_data(1'b0, 32'h44, 1);
        rd_addr(1'b0, 8'hFE);
        rd_data(1'b0, 32'h112233, 3);
        rd_addr(1'b0, 8'h01);
        rd_data(1'b0, 32'h44, 1);

        $display("[TB] fixed pointer");
        wr_addr(1'b1, 8'h05);
        wr_data(1'b1, 32'h0FF0, 2);
        rd_addr(1'b1, 8'h05);
        rd_data(1'b1, 32'hF0F0, 2);
        settle();
        checkOutput("fixed_no_abort", abort_cnt_b, 0);

        $display("[TB] aborts");
        wr_addr(1'b0, 8'h12);
        applyStimulus(1'b0, 32'b01, 2, 1'b0);
        applyStimulus(1'b0, 32'b00000, 5, 1'b0);
        end_frame(1'b0);
        settle();
        checkOutput("abort_wdata", abort_cnt_a, 1);
        rd_addr(1'b0, 8'h12);
        rd_data(1'b0, 32'hA5, 1);
        wr_data(1'b0, 32'h5A, 1);
        rd_addr(1'b0, 8'h12);
        applyStimulus(1'b0, 32'b10111, 5, 1'b0);
        end_frame(1'b0);
        settle();
        checkOutput("abort_raddr", abort_cnt_a, 2);
        rd_data(1'b0, 32'h5A, 1);
        applyStimulus(1'b0, 32'b0, 1, 1'b0);
        end_frame(1'b0);
        settle();
        checkOutput("abort_cmd", abort_cnt_a, 3);
        rd_addr(1'b0, 8'h12);
        applyStimulus(1'b0, 32'b110, 3, 1'b0);
        applyStimulus(1'b0, 32'b1111, 4, 1'b0);
        end_frame(1'b0);
        settle();
        checkOutput("partial_read_no_abort", abort_cnt_a, 3);

        $display("[TB] reset mid-frame");
        rd_addr(1'b0, 8'hFE);
        applyStimulus(1'b0, 32'b1100000, 7, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_busy", {31'd0, busy_a}, 32'd1);
        checkOutput("pre_reset_miso", {31'd0, miso_a}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_miso", {31'd0, miso_a}, 32'd0);
        checkOutput("async_reset_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        ss_n_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_data(1'b0, 32'h33, 1);
        wr_data(1'b0, 32'h77, 1);
        rd_addr(1'b0, 8'h00);
        rd_data(1'b0, 32'h77, 1);
        rd_addr(1'b0, 8'hFE);
        rd_data(1'b0, 32'h1122, 2);

        $display("[TB] back-to-back frames");
        wr_addr(1'b0, 8'h20);
        wr_data(1'b0, 32'h3C, 1);
        rd_addr(1'b0, 8'h20);
        rd_data(1'b0, 32'h3C, 1);
        settle();
        checkOutput("final_abort_count_a", abort_cnt_a, 3);
        checkOutput("pending_words_a", exp_a.size(), 0);
        checkOutput("pending_words_b", exp_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst_slave.md
# spi_ram_burst_slave

Parametrised SPI slave with an on-chip single-port RAM that supports burst transfers. It is the next generation of the 10-bit SPI/RAM wrapper:
- address and data widths are parameters;
- streaming multi-word writes and reads are supported within one SS_n frame, with optional pointer auto-increment;
- there is a frame-abort indication.

It sits at the chip pin boundary. MOSI is sampled and MISO is driven in the `clk` domain, one bit per `clk` cycle.

## Interface
- ADDR_WIDTH, 8, pointer/address width; memory depth is fixed at 2**ADDR_WIDTH words
- DATA_WIDTH, 8, RAM word width and SPI data word length
- AUTO_INC, 1, 1 = pointer advances after every data word (burst); 0 = pointer holds (every word hits the same address)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- MOSI  input  1  serial data in, MSB first
- SS_n  input  1  active-low frame select
- MISO  output  1  serial data out, registered
- busy  output  1  high while a frame is in progress (state != IDLE)
- abort  output  1  one-cycle pulse: frame ended mid-address or mid-word

## Operation
- **Bit numbering.** Bit index k counts rising edges with SS_n=0 since frame start. k=0 is the first such edge.
- **Command.** Bits k=0,1 form a 2-bit command, MSB first:
  - 00 WR_ADDR
  - 01 WR_DATA
  - 10 RD_ADDR
  - 11 RD_DATA
- **States:** IDLE, CMD, WADDR, WDATA, RADDR, RTURN, RDATA.
  - IDLE -> CMD on the first edge with SS_n=0.
  - CMD -> target state on the edge sampling k=1.
  - Any state -> IDLE on any edge with SS_n=1.
- **WR_ADDR.** Bits k=2..ADDR_WIDTH+1 shift into wptr on the edge sampling the last bit. Later bits in the frame are ignored.
- **RD_ADDR.** Same as WR_ADDR, but targets rptr.
- **WR_DATA.**
  - Word n occupies k=2+n·DATA_WIDTH .. 1+(n+1)·DATA_WIDTH.
  - mem[wptr] is written on the edge sampling the word's last bit.
  - If AUTO_INC=1, wptr increments on that same edge, mod 2**ADDR_WIDTH, so 2**ADDR_WIDTH-1 wraps to 0.
- **RD_DATA.**
  - k=2 is a turnaround bit. MOSI is ignored; mem[rptr] is read into the shift register.
  - Bits are then shifted out MSB first, with no gap between words.
  - When the shift register loads a word, the next word, mem[rptr+AUTO_INC], is prefetched. rptr advances on each load, with wrap.
  - MOSI is ignored in RDATA.
- **Write-then-read ordering.** A read address equal to the word just written returns the new data. Write and read are in separate frames, so no bypass is needed.
- **MISO outside RDATA.** MISO is 0 whenever the state is not RTURN/RDATA.
- **Abort.** On SS_n rise, abort pulses for the cycle after the edge on which SS_n was sampled high, in these cases:
  - A WADDR/RADDR field is incomplete. The pointer is unchanged.
  - A WDATA word is incomplete. The partial word is discarded; no write, no increment.
  - A frame ends in CMD.
- **Cases that do not abort:**
  - A frame ending in RDATA never aborts. Partial read words are normal.
  - SS_n high with the state already IDLE gives no pulse.
- **Reset.** rst asserted at any time, including mid-frame:
  - state = IDLE, wptr = rptr = 0, shift registers = 0;
  - MISO = 0, busy = 0, abort = 0;
  - RAM contents are not cleared.

  After rst deasserts, a frame begins only on a fresh SS_n low edge sample. If SS_n is already low, the next edge counts as k=0.

## Timing
- Reset values: MISO=0, busy=0, abort=0, wptr=rptr=0.
- busy rises on the edge sampling k=0. It falls on the edge sampling SS_n=1.
- Write latency: the RAM is updated on the edge sampling the last data bit. The data is readable from the next frame.
- Read latency: MISO shows bit DATA_WIDTH-1 of word n after edge k=3+n·DATA_WIDTH. It shows bit j after edge k=3+n·DATA_WIDTH+(DATA_WIDTH-1-j).
- Minimum SS_n high between frames: 1 clk.
- Frame length: unlimited. Bursts longer than the memory depth wrap.

## Test plan
- **Single write/read.** Frame 00 + 0x12, then frame 01 + 0xA5, then frame 10 + 0x12, then frame 11 with 8+1 clocks. Required: MISO after k=3..10 = 1,0,1,0,0,1,0,1; abort never pulses.
- **Burst write with wrap.** AUTO_INC=1: set wptr=0xFE, write 0x11,0x22,0x33 in one frame; read back from rptr=0xFE. Required: 0x11,0x22,0x33 from 0xFE,0xFF,0x00.
- **AUTO_INC=0.** Two-word write 0x0F,0xF0 at address 5, then a 2-word read. Required: both read words are 0xF0.
- **Aborts.** SS_n rises after 5 data bits of WR_DATA, then after 3 address bits of RD_ADDR. Required: one abort pulse each time; addressed word and rptr unchanged.
- **Reset mid-frame.** Assert rst during RDATA bit 4. Required: MISO=0 and busy=0 immediately (asynchronous); wptr=rptr=0 afterwards; RAM data written earlier still reads back correctly.
- **Back-to-back frames.** Frames separated by 1-cycle SS_n high. Required: each frame decodes its command from its own k=0,1.
